// File: rtl/adder_ctrl_pkg.sv
// Shared types and defaults for the accumulator control stage that drives the 16-bit adder.
package adder_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WRITE  = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/button_sync_edge.sv
// Synchronises one asynchronous push-button and emits a single-cycle pulse on its rising edge.
module button_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Btn,
    output logic Pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Btn};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A held button stays high in both taps, so only the 0->1 step produces a pulse.
    assign Pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/adder_accumulate_ctrl.sv
// Accumulator/operand registers around an external combinational adder: A <= A + B on each Run,
// after holding the operands stable for a fixed number of settle cycles.
module adder_accumulate_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH         = DEFAULT_WIDTH,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Switches,
    input  logic             LoadB,
    input  logic             ClearA,
    input  logic             Run,
    input  logic [WIDTH-1:0] Adder_Sum,
    input  logic             Adder_CO,
    output logic [WIDTH-1:0] Op_A,
    output logic [WIDTH-1:0] Op_B,
    output logic             Carry,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic load_ev;
    logic clear_ev;
    logic run_ev;

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;

    button_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_load (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Btn     (LoadB),
        .Pulse   (load_ev)
    );

    button_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_clear (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Btn     (ClearA),
        .Pulse   (clear_ev)
    );

    button_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_run (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Btn     (Run),
        .Pulse   (run_ev)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        unique case (state_q)
            IDLE: begin
                if (clear_ev) begin
                    a_d     = '0;
                    carry_d = 1'b0;
                end
                if (load_ev) begin
                    b_d = Switches;
                end
                // A register update in the same cycle takes priority; the Run press is dropped.
                if (run_ev && !clear_ev && !load_ev) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WRITE: begin
                a_d     = Adder_Sum;
                carry_d = Adder_CO;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
        end
    end

    assign Op_A  = a_q;
    assign Op_B  = b_q;
    assign Carry = carry_q;
    assign Busy  = (state_q != IDLE);
    assign Done  = (state_q == WRITE);

endmodule

// File: tb/tb_adder_accumulate_ctrl.sv
// Bench for adder_accumulate_ctrl with a behavioural 16-bit adder and an arithmetic reference model.
module tb_adder_accumulate_ctrl;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned SYNC   = 2;
    // Edges from driving Run high to Done being visible: synchroniser, then SETTLE+1 cycles.
    localparam int          EXP_LAT = SYNC + SETTLE + 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] switches;
    logic             loadb;
    logic             cleara;
    logic             run;
    logic [WIDTH-1:0] adder_sum;
    logic             adder_co;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   sum_full;

    int total;
    int bad;

    // Reference model state
    logic [WIDTH-1:0] a_m;
    logic [WIDTH-1:0] b_m;
    logic             carry_m;

    assign sum_full  = {1'b0, op_a} + {1'b0, op_b};
    assign adder_sum = sum_full[WIDTH-1:0];
    assign adder_co  = sum_full[WIDTH];

    adder_accumulate_ctrl #(
        .WIDTH         (WIDTH),
        .SETTLE_CYCLES (SETTLE),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .Switches  (switches),
        .LoadB     (loadb),
        .ClearA    (cleara),
        .Run       (run),
        .Adder_Sum (adder_sum),
        .Adder_CO  (adder_co),
        .Op_A      (op_a),
        .Op_B      (op_b),
        .Carry     (carry),
        .Busy      (busy),
        .Done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_add();
        logic [WIDTH:0] s;
        s       = {1'b0, a_m} + {1'b0, b_m};
        a_m     = s[WIDTH-1:0];
        carry_m = s[WIDTH];
    endtask

    task automatic press_load(input logic [WIDTH-1:0] val);
        switches = val;
        loadb    = 1'b1;
        repeat (4) step();
        loadb = 1'b0;
        repeat (3) step();
        b_m = val;
    endtask

    task automatic press_clear();
        cleara = 1'b1;
        repeat (4) step();
        cleara = 1'b0;
        repeat (3) step();
        a_m     = '0;
        carry_m = 1'b0;
    endtask

    // Presses Run once; reports edges until Done first seen (-1 if never) and total Done cycles.
    task automatic press_run(output int lat, output int ndone);
        lat   = -1;
        ndone = 0;
        run   = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (done) begin
                ndone++;
                if (lat < 0) lat = i;
            end
            if (i == 3) run = 1'b0;
        end
        model_add();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #10;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        a_m = '0; b_m = '0; carry_m = 1'b0;
        total++; if (op_a !== 16'h0)  begin bad++; $display("FAIL reset_op_a got=%h want=0", op_a); end
        total++; if (op_b !== 16'h0)  begin bad++; $display("FAIL reset_op_b got=%h want=0", op_b); end
        total++; if (carry !== 1'b0)  begin bad++; $display("FAIL reset_carry got=%b want=0", carry); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    endtask

    task automatic test_basic_add();
        int lat, nd;
        press_load(16'h1234);
        for (int k = 0; k < 2; k++) begin
            press_run(lat, nd);
            total++;
            if (lat != EXP_LAT || nd != 1) begin
                bad++;
                $display("FAIL basic_latency[%0d] got lat=%0d dones=%0d want lat=%0d dones=1",
                         k, lat, nd, EXP_LAT);
            end
            total++;
            if (op_a !== a_m) begin bad++; $display("FAIL basic_op_a[%0d] got=%h want=%h", k, op_a, a_m); end
        end
        total++; if (op_a !== 16'h2468) begin bad++; $display("FAIL basic_sum got=%h want=2468", op_a); end
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL basic_carry got=%b want=0", carry); end
    endtask

    task automatic test_overflow();
        int lat, nd;
        press_clear();
        press_load(16'hFFFF);
        press_run(lat, nd);
        press_load(16'h0001);
        press_run(lat, nd);
        total++; if (op_a !== 16'h0000) begin bad++; $display("FAIL ovf_op_a got=%h want=0000", op_a); end
        total++; if (carry !== 1'b1) begin bad++; $display("FAIL ovf_carry got=%b want=1", carry); end
        press_clear();
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL ovf_clear_carry got=%b want=0", carry); end
    endtask

    task automatic test_hold_and_busy();
        int nd;
        logic saw_busy;
        press_load(16'h0003);
        nd  = 0;
        run = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (done) nd++;
        end
        run = 1'b0;
        repeat (4) step();
        model_add();
        total++; if (nd != 1) begin bad++; $display("FAIL hold_run_dones got=%0d want=1", nd); end
        total++; if (op_a !== a_m) begin bad++; $display("FAIL hold_run_op_a got=%h want=%h", op_a, a_m); end

        // Second Run and a LoadB rising while the add is in flight must both be dropped.
        nd       = 0;
        saw_busy = 1'b0;
        run      = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (done) nd++;
            if (i == 3 && busy) saw_busy = 1'b1;
            if (i == 1) run = 1'b0;
            if (i == 2) begin
                run      = 1'b1;
                loadb    = 1'b1;
                switches = 16'h00AA;
            end
            if (i == 6) begin
                run   = 1'b0;
                loadb = 1'b0;
            end
        end
        model_add();
        total++; if (!saw_busy) begin bad++; $display("FAIL busy_high got=0 want=1"); end
        total++; if (nd != 1) begin bad++; $display("FAIL busy_discard_dones got=%0d want=1", nd); end
        total++; if (op_b !== b_m) begin bad++; $display("FAIL busy_op_b got=%h want=%h", op_b, b_m); end
        total++; if (op_a !== a_m) begin bad++; $display("FAIL busy_op_a got=%h want=%h", op_a, a_m); end
    endtask

    task automatic test_simultaneous();
        logic saw_busy;
        saw_busy = 1'b0;
        switches = 16'h0F0F;
        cleara   = 1'b1;
        loadb    = 1'b1;
        run      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy) saw_busy = 1'b1;
        end
        cleara = 1'b0;
        loadb  = 1'b0;
        run    = 1'b0;
        repeat (3) step();
        a_m = '0; carry_m = 1'b0; b_m = 16'h0F0F;
        total++; if (saw_busy) begin bad++; $display("FAIL simul_busy got=1 want=0"); end
        total++; if (op_a !== a_m) begin bad++; $display("FAIL simul_op_a got=%h want=%h", op_a, a_m); end
        total++; if (op_b !== b_m) begin bad++; $display("FAIL simul_op_b got=%h want=%h", op_b, b_m); end
    endtask

    task automatic test_reset_mid_op();
        int nd, lat;
        press_load(16'h0101);
        nd  = 0;
        run = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            if (done) nd++;
        end
        run = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        for (int i = 0; i < 5; i++) begin
            step();
            if (done) nd++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) nd++;
        end
        a_m = '0; b_m = '0; carry_m = 1'b0;
        total++; if (nd != 0) begin bad++; $display("FAIL midrst_dones got=%0d want=0", nd); end
        total++; if (op_a !== a_m) begin bad++; $display("FAIL midrst_op_a got=%h want=%h", op_a, a_m); end
        press_load(16'h0055);
        press_run(lat, nd);
        total++;
        if (lat != EXP_LAT || nd != 1) begin
            bad++;
            $display("FAIL midrst_rerun got lat=%0d dones=%0d want lat=%0d dones=1", lat, nd, EXP_LAT);
        end
        total++; if (op_a !== a_m) begin bad++; $display("FAIL midrst_rerun_op_a got=%h want=%h", op_a, a_m); end
    endtask

    task automatic test_random();
        int lat, nd;
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0) press_clear();
            if ($urandom_range(0, 1) == 1) press_load(16'($urandom));
            press_run(lat, nd);
            total++;
            if (op_a !== a_m || carry !== carry_m || op_b !== b_m) begin
                bad++;
                $display("FAIL random[%0d] got a=%h b=%h c=%b want a=%h b=%h c=%b",
                         k, op_a, op_b, carry, a_m, b_m, carry_m);
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        switches = '0;
        loadb    = 1'b0;
        cleara   = 1'b0;
        run      = 1'b0;
        a_m      = '0;
        b_m      = '0;
        carry_m  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        test_reset();
        test_basic_add();
        test_overflow();
        test_hold_and_busy();
        test_simultaneous();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
